fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
// Parametrised operand-bypass and hazard unit. It sits between the ID and EX stages of the RISC-V pipeline.
// It supersedes the fixed Rs1/alu/pc, Rs2/alu/imm operand muxes with a tracked in-flight write window of DEPTH stages.
// It forwards the youngest ready result, generates load-use stalls, registers EX operands and branch flags, and drives the regfile write port.
// PARAMETERS
// XLEN      32  datapath width
// AW        5   register address width (x0..x(2^AW-1))
// DEPTH     3   in-flight stages tracked (entry0=EX .. entry[DEPTH-1]=WB), DEPTH>=2
// LOAD_LAT  1   stage index at which load data is valid (1<=LOAD_LAT<DEPTH)
// PORTS
// clk            in   1     clock, rising edge
// rst            in   1     asynchronous reset, active-low
// id_valid       in   1     instruction valid in ID
// id_rs1,id_rs2  in   AW    source register addresses
// id_rs1_val     in   XLEN  regfile read data for rs1
// id_rs2_val     in   XLEN  regfile read data for rs2
// id_pc,id_imm   in   XLEN  PC and immediate of ID instruction
// id_a_pc        in   1     1: op_a=pc, 0: op_a=fwd rs1
// id_b_imm       in   1     1: op_b=imm, 0: op_b=fwd rs2
// id_brun        in   1     1: unsigned branch compare
// id_rd          in   AW    destination register
// id_we          in   1     instruction writes rd
// id_is_load     in   1     instruction is a load
// flush          in   1     kill ID instruction (taken branch/jump)
// ex_result      in   XLEN  ALU result of entry0 (combinational, same cycle)
// mem_rdata      in   XLEN  load data belonging to entry[LOAD_LAT]
// stall          out  1     combinational; ID/IF must hold
// ex_valid       out  1     EX holds a real instruction
// ex_op_a,ex_op_b out XLEN  registered EX operands
// ex_store_data  out  XLEN  registered forwarded rs2 (store data)
// ex_breq,ex_brlt out 1     registered compare of fwd rs1 vs fwd rs2
// wb_we,wb_rd,wb_data out 1/AW/XLEN  regfile write from entry[DEPTH-1]
// BEHAVIOUR
// - Entry k holds {we,rd,is_load,data}. Each cycle entry[k]<=entry[k-1] with resolved data of k-1; entry0<=ID instruction or a bubble (we=0).
// - Resolved data: k=0 non-load -> ex_result; k==LOAD_LAT load -> mem_rdata; otherwise stored data.
// - Entry k is ready if !is_load or k>=LOAD_LAT.
// - Forward per source: scan k=0..DEPTH-1. The first (youngest) entry with we && rd==rs && rs!=0 is the match.
// - If the match is ready, use its data. If the match is not ready, assert stall. If there is no match, use id_rsX_val.
// - rs==0 always yields 0, never stalls.
// - stall = id_valid && !flush && (rs1 or rs2 youngest match not ready); both sources are checked regardless of id_a_pc/id_b_imm.
// - stall=1 or flush=1 or id_valid=0: the next cycle has ex_valid=0 and entry0 is a bubble.
// - In those bubble cycles ex_op_a/ex_op_b/ex_store_data/ex_breq/ex_brlt hold their previous values. The pipeline keeps shifting.
// - Latency: operands, flags and ex_valid update 1 cycle after ID presentation.
// - ex_breq = (a==b) on forwarded rs values. ex_brlt = signed a<b, or unsigned when id_brun=1.
// - wb_*: combinational from entry[DEPTH-1]. The regfile commits on clk, so an instruction leaving the window is visible in id_rsX_val next cycle.
// - wb_we=0 when wb_rd==0.
// - Flush has priority over stall. Simultaneous older-entry shift and new match are evaluated on pre-edge state.
// - Reset (any time, asynchronous): all entries we=0/data=0, ex_valid=0, ex_op_a=ex_op_b=ex_store_data=0, ex_breq=ex_brlt=0, stall=0.
// - On reset, in-flight instructions are discarded.
// TESTING
// - x1=5 in regfile, no in-flight writes, ID add rs1=x1,rs2=x0 -> next cycle ex_op_a=5, ex_op_b=0, ex_breq=0, stall=0.
// - EX writes x3 (ex_result=0xDDDDDDDD), ID reads rs1=x3 -> ex_op_a=0xDDDDDDDD. With id_b_imm=1, imm=0xFFFFFFFF -> ex_op_b=0xFFFFFFFF.
// - x3 written by entry0 (0x11) and entry1 (0x22), ID reads x3 -> youngest wins, ex_op_a=0x11.
// - Load to x4 in EX, ID reads rs2=x4 -> stall=1 one cycle, ex_valid=0. Next cycle mem_rdata=0x1234 -> ex_store_data=0x1234, stall=0.
// - Load-use stall with flush=1 same cycle -> stall=0, ex_valid=0 next cycle, no entry allocated.
// - rs1=0xFFFFFFFF, rs2=1: brun=0 -> ex_brlt=1; brun=1 -> ex_brlt=0.
// - Reset mid-stream -> all outputs 0 immediately. The first ID read after reset returns id_rsX_val unforwarded.

Source files
------------

// File: rtl/fwd_hazard_unit_if.sv
// ID/EX bypass bus: ID instruction fields, EX/MEM result feedback,
// and the registered EX operands plus the regfile write port.
interface fwd_hazard_unit_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            id_valid;
  logic [AW-1:0]   id_rs1;
  logic [AW-1:0]   id_rs2;
  logic [XLEN-1:0] id_rs1_val;
  logic [XLEN-1:0] id_rs2_val;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_imm;
  logic            id_a_pc;
  logic            id_b_imm;
  logic            id_brun;
  logic [AW-1:0]   id_rd;
  logic            id_we;
  logic            id_is_load;
  logic            flush;
  logic [XLEN-1:0] ex_result;
  logic [XLEN-1:0] mem_rdata;

  logic            stall;
  logic            ex_valid;
  logic [XLEN-1:0] ex_op_a;
  logic [XLEN-1:0] ex_op_b;
  logic [XLEN-1:0] ex_store_data;
  logic            ex_breq;
  logic            ex_brlt;
  logic            wb_we;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;

  // Pipeline side: presents ID instructions and result feedback
  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_val, id_rs2_val, id_pc, id_imm,
           id_a_pc, id_b_imm, id_brun, id_rd, id_we, id_is_load, flush,
           ex_result, mem_rdata,
    input  stall, ex_valid, ex_op_a, ex_op_b, ex_store_data, ex_breq, ex_brlt,
           wb_we, wb_rd, wb_data
  );

  // Bypass/hazard unit side
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_val, id_rs2_val, id_pc, id_imm,
           id_a_pc, id_b_imm, id_brun, id_rd, id_we, id_is_load, flush,
           ex_result, mem_rdata,
    output stall, ex_valid, ex_op_a, ex_op_b, ex_store_data, ex_breq, ex_brlt,
           wb_we, wb_rd, wb_data
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand bypass and load-use hazard unit between ID and EX.
// Tracks DEPTH in-flight writers (entry0=EX .. entry[DEPTH-1]=WB), forwards
// the youngest ready result per source, stalls on not-yet-ready loads,
// registers EX operands/branch flags and drives the regfile write port.
module fwd_hazard_unit #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  fwd_hazard_unit_if.slave     bus
);

  // In-flight window; data holds the resolved value once known
  logic            r_we   [DEPTH];
  logic [AW-1:0]   r_rd   [DEPTH];
  logic            r_ld   [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];

  logic [XLEN-1:0] w_res  [DEPTH];
  logic            w_rdy  [DEPTH];

  logic [XLEN-1:0] w_fwd1, w_fwd2;
  logic            w_hit1, w_hit2;
  logic            w_haz1, w_haz2;
  logic            w_stall;
  logic            w_accept;

  // EX stage registers
  logic            r_vld_p1;
  logic [XLEN-1:0] r_op_a_p1;
  logic [XLEN-1:0] r_op_b_p1;
  logic [XLEN-1:0] r_sdata_p1;
  logic            r_breq_p1;
  logic            r_brlt_p1;

  function automatic logic br_lt(input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b,
                                 input logic            uns);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sa = a;
    sb = b;
    return uns ? (a < b) : (sa < sb);
  endfunction

  // Resolve each entry's value this cycle and whether it may be forwarded
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_rdy[k] = !r_ld[k] || (k >= LOAD_LAT);
      if (k == 0 && !r_ld[k])
        w_res[k] = bus.ex_result;
      else if (k == LOAD_LAT && r_ld[k])
        w_res[k] = bus.mem_rdata;
      else
        w_res[k] = r_data[k];
    end
  end

  // Youngest-match scan for both sources; x0 always reads zero
  always_comb begin
    w_fwd1 = bus.id_rs1_val;
    w_fwd2 = bus.id_rs2_val;
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    w_haz1 = 1'b0;
    w_haz2 = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!w_hit1 && r_we[k] && (r_rd[k] == bus.id_rs1)) begin
        w_hit1 = 1'b1;
        w_fwd1 = w_res[k];
        w_haz1 = !w_rdy[k];
      end
      if (!w_hit2 && r_we[k] && (r_rd[k] == bus.id_rs2)) begin
        w_hit2 = 1'b1;
        w_fwd2 = w_res[k];
        w_haz2 = !w_rdy[k];
      end
    end
    if (bus.id_rs1 == '0) begin
      w_fwd1 = '0;
      w_haz1 = 1'b0;
    end
    if (bus.id_rs2 == '0) begin
      w_fwd2 = '0;
      w_haz2 = 1'b0;
    end
  end

  // Flush wins over stall; only a surviving, hazard-free instruction enters EX
  always_comb begin
    w_stall  = bus.id_valid && !bus.flush && (w_haz1 || w_haz2);
    w_accept = bus.id_valid && !bus.flush && !w_stall;
  end

  // ---- ID -> window: shift every cycle, entry0 gets instruction or bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_we[k]   <= 1'b0;
        r_rd[k]   <= '0;
        r_ld[k]   <= 1'b0;
        r_data[k] <= '0;
      end
    end else begin
      r_we[0]   <= w_accept && bus.id_we;
      r_rd[0]   <= w_accept ? bus.id_rd : '0;
      r_ld[0]   <= w_accept && bus.id_is_load;
      r_data[0] <= '0;
      for (int k = 1; k < DEPTH; k++) begin
        r_we[k]   <= r_we[k-1];
        r_rd[k]   <= r_rd[k-1];
        r_ld[k]   <= r_ld[k-1];
        r_data[k] <= w_res[k-1];
      end
    end
  end

  // ---- ID -> EX: operands and branch flags hold during bubbles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p1   <= 1'b0;
      r_op_a_p1  <= '0;
      r_op_b_p1  <= '0;
      r_sdata_p1 <= '0;
      r_breq_p1  <= 1'b0;
      r_brlt_p1  <= 1'b0;
    end else begin
      r_vld_p1 <= w_accept;
      if (w_accept) begin
        r_op_a_p1  <= bus.id_a_pc  ? bus.id_pc  : w_fwd1;
        r_op_b_p1  <= bus.id_b_imm ? bus.id_imm : w_fwd2;
        r_sdata_p1 <= w_fwd2;
        r_breq_p1  <= (w_fwd1 == w_fwd2);
        r_brlt_p1  <= br_lt(w_fwd1, w_fwd2, bus.id_brun);
      end
    end
  end

  assign bus.stall         = w_stall;
  assign bus.ex_valid      = r_vld_p1;
  assign bus.ex_op_a       = r_op_a_p1;
  assign bus.ex_op_b       = r_op_b_p1;
  assign bus.ex_store_data = r_sdata_p1;
  assign bus.ex_breq       = r_breq_p1;
  assign bus.ex_brlt       = r_brlt_p1;

  // Oldest entry retires into the regfile; x0 writes are suppressed
  assign bus.wb_we   = r_we[DEPTH-1] && (r_rd[DEPTH-1] != '0);
  assign bus.wb_rd   = r_rd[DEPTH-1];
  assign bus.wb_data = w_res[DEPTH-1];

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the in-flight window
// and a bench-owned register file.
module tb_fwd_hazard_unit;
  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  fwd_hazard_unit_if #(.XLEN(XLEN), .AW(AW)) bus ();

  fwd_hazard_unit #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: register file, in-flight writers (index = age), EX expectations
  logic [31:0] mrf     [32];
  bit          win_we  [DEPTH];
  logic [4:0]  win_rd  [DEPTH];
  bit          win_ld  [DEPTH];
  logic [31:0] win_val [DEPTH];
  logic [31:0] e_a, e_b, e_sd;
  bit          e_eq, e_lt, e_v;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) begin
      win_we[k] = 0; win_rd[k] = '0; win_ld[k] = 0; win_val[k] = '0;
    end
    e_a = '0; e_b = '0; e_sd = '0; e_eq = 0; e_lt = 0; e_v = 0;
  endtask

  // Is the value of the writer of age k known this cycle, and what is it
  task automatic avail(input int k, output bit ok, output logic [31:0] v);
    ok = 1;
    v  = win_val[k];
    if (!win_ld[k]) begin
      if (k == 0) v = bus.ex_result;
    end else if (k == LOAD_LAT) begin
      v = bus.mem_rdata;
    end else if (k < LOAD_LAT) begin
      ok = 0;
      v  = '0;
    end
  endtask

  task automatic lookup(input logic [4:0] rs, input logic [31:0] rfv,
                        output logic [31:0] v, output bit haz);
    bit          found;
    bit          ok;
    logic [31:0] t;
    v = rfv; haz = 0; found = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && win_we[k] && win_rd[k] == rs) begin
        found = 1;
        avail(k, ok, t);
        v   = t;
        haz = !ok;
      end
    end
    if (rs == 5'd0) begin
      v = '0; haz = 0;
    end
  endtask

  // Compare all outputs against the model, then advance it across the next edge
  task automatic check_cycle();
    logic [31:0] f1, f2, wv, t;
    bit          h1, h2, es, ewe, acc, ok;
    lookup(bus.id_rs1, bus.id_rs1_val, f1, h1);
    lookup(bus.id_rs2, bus.id_rs2_val, f2, h2);
    es  = bus.id_valid && !bus.flush && (h1 || h2);
    ewe = win_we[DEPTH-1] && (win_rd[DEPTH-1] != 5'd0);
    avail(DEPTH-1, ok, wv);
    cmp("stall", 32'(bus.stall), 32'(es));
    cmp("wb_we", 32'(bus.wb_we), 32'(ewe));
    if (ewe) begin
      cmp("wb_rd", 32'(bus.wb_rd), 32'(win_rd[DEPTH-1]));
      cmp("wb_data", bus.wb_data, wv);
    end
    cmp("ex_valid", 32'(bus.ex_valid), 32'(e_v));
    cmp("ex_op_a", bus.ex_op_a, e_a);
    cmp("ex_op_b", bus.ex_op_b, e_b);
    cmp("ex_store_data", bus.ex_store_data, e_sd);
    cmp("ex_breq", 32'(bus.ex_breq), 32'(e_eq));
    cmp("ex_brlt", 32'(bus.ex_brlt), 32'(e_lt));

    acc = bus.id_valid && !bus.flush && !es;
    e_v = acc;
    if (acc) begin
      e_a  = bus.id_a_pc  ? bus.id_pc  : f1;
      e_b  = bus.id_b_imm ? bus.id_imm : f2;
      e_sd = f2;
      e_eq = (f1 == f2);
      e_lt = bus.id_brun ? (f1 < f2) : ($signed(f1) < $signed(f2));
    end
    if (ewe) mrf[win_rd[DEPTH-1]] = wv;
    for (int k = DEPTH-1; k >= 1; k--) begin
      avail(k-1, ok, t);
      win_we[k] = win_we[k-1]; win_rd[k] = win_rd[k-1];
      win_ld[k] = win_ld[k-1]; win_val[k] = t;
    end
    win_we[0]  = acc && bus.id_we;
    win_rd[0]  = acc ? bus.id_rd : 5'd0;
    win_ld[0]  = acc && bus.id_is_load;
    win_val[0] = '0;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rf();
    bus.id_rs1_val = (bus.id_rs1 == 5'd0) ? $urandom : mrf[bus.id_rs1];
    bus.id_rs2_val = (bus.id_rs2 == 5'd0) ? $urandom : mrf[bus.id_rs2];
  endtask

  task automatic setid(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input bit we, input bit ld, input bit fl);
    bus.id_valid = v;   bus.id_rs1 = rs1; bus.id_rs2 = rs2;
    bus.id_rd = rd;     bus.id_we = we;   bus.id_is_load = ld;
    bus.flush = fl;     bus.id_a_pc = 0;  bus.id_b_imm = 0; bus.id_brun = 0;
    bus.id_pc = $urandom; bus.id_imm = $urandom;
    drive_rf();
  endtask

  task automatic drive_rand();
    bus.id_valid   = ($urandom_range(0, 7) != 0);
    bus.id_rs1     = 5'($urandom_range(0, 7));
    bus.id_rs2     = 5'($urandom_range(0, 7));
    bus.id_rd      = 5'($urandom_range(0, 7));
    bus.id_we      = ($urandom_range(0, 3) != 0);
    bus.id_is_load = ($urandom_range(0, 2) == 0);
    bus.flush      = ($urandom_range(0, 9) == 0);
    bus.id_a_pc    = 1'($urandom_range(0, 1));
    bus.id_b_imm   = 1'($urandom_range(0, 1));
    bus.id_brun    = 1'($urandom_range(0, 1));
    bus.id_pc      = $urandom;
    bus.id_imm     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
    bus.ex_result  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
    bus.mem_rdata  = $urandom;
    drive_rf();
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, "_stall"},    32'(bus.stall),    32'd0);
    cmp({tag, "_ex_valid"}, 32'(bus.ex_valid), 32'd0);
    cmp({tag, "_op_a"},     bus.ex_op_a,       32'd0);
    cmp({tag, "_op_b"},     bus.ex_op_b,       32'd0);
    cmp({tag, "_sdata"},    bus.ex_store_data, 32'd0);
    cmp({tag, "_breq"},     32'(bus.ex_breq),  32'd0);
    cmp({tag, "_brlt"},     32'(bus.ex_brlt),  32'd0);
    cmp({tag, "_wb_we"},    32'(bus.wb_we),    32'd0);
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mrf[i] = $urandom;
    mrf[0] = '0;
    bus.ex_result = '0;
    bus.mem_rdata = '0;
    setid(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    #1;
    rst = 1'b1;

    // x1=5, nothing in flight: plain regfile read, x0 reads zero
    mrf[1] = 32'd5;
    setid(1, 5'd1, 5'd0, 5'd0, 0, 0, 0);
    step();
    cmp("t1_op_a", bus.ex_op_a, 32'd5);
    cmp("t1_op_b", bus.ex_op_b, 32'd0);
    cmp("t1_breq", 32'(bus.ex_breq), 32'd0);

    // EX result forwarded to rs1; op_b from immediate
    setid(1, 5'd0, 5'd0, 5'd3, 1, 0, 0);
    step();
    setid(1, 5'd3, 5'd0, 5'd0, 0, 0, 0);
    bus.id_b_imm = 1; bus.id_imm = 32'hFFFF_FFFF; bus.ex_result = 32'hDDDD_DDDD;
    step();
    cmp("t2_op_a", bus.ex_op_a, 32'hDDDD_DDDD);
    cmp("t2_op_b", bus.ex_op_b, 32'hFFFF_FFFF);

    // Two in-flight writers of x3: youngest wins
    setid(1, 5'd0, 5'd0, 5'd3, 1, 0, 0);
    step();
    setid(1, 5'd0, 5'd0, 5'd3, 1, 0, 0);
    bus.ex_result = 32'h22;
    step();
    setid(1, 5'd3, 5'd0, 5'd0, 0, 0, 0);
    bus.ex_result = 32'h11;
    step();
    cmp("t3_youngest", bus.ex_op_a, 32'h11);

    // Load-use on rs2: one stall cycle, then load data forwarded as store data
    setid(1, 5'd0, 5'd0, 5'd4, 1, 1, 0);
    step();
    setid(1, 5'd0, 5'd4, 5'd0, 0, 0, 0);
    bus.mem_rdata = 32'h0;
    #1 cmp("t4_stall_on", 32'(bus.stall), 32'd1);
    step();
    cmp("t4_bubble", 32'(bus.ex_valid), 32'd0);
    bus.mem_rdata = 32'h1234;
    #1 cmp("t4_stall_off", 32'(bus.stall), 32'd0);
    step();
    cmp("t4_sdata", bus.ex_store_data, 32'h1234);
    cmp("t4_valid", 32'(bus.ex_valid), 32'd1);

    // Load-use hazard killed by flush: no stall, no EX instruction
    setid(1, 5'd0, 5'd0, 5'd4, 1, 1, 0);
    step();
    setid(1, 5'd4, 5'd0, 5'd9, 1, 0, 1);
    #1 cmp("t5_flush_stall", 32'(bus.stall), 32'd0);
    step();
    cmp("t5_flush_valid", 32'(bus.ex_valid), 32'd0);

    // Signed vs unsigned less-than
    setid(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    repeat (DEPTH + 1) step();
    mrf[5] = 32'hFFFF_FFFF;
    mrf[6] = 32'd1;
    setid(1, 5'd5, 5'd6, 5'd0, 0, 0, 0);
    step();
    cmp("t6_brlt_signed", 32'(bus.ex_brlt), 32'd1);
    setid(1, 5'd5, 5'd6, 5'd0, 0, 0, 0);
    bus.id_brun = 1;
    step();
    cmp("t6_brlt_unsigned", 32'(bus.ex_brlt), 32'd0);

    // Randomized traffic
    repeat (400) begin
      drive_rand();
      step();
    end

    // Asynchronous reset with a load-use stall pending
    setid(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    repeat (DEPTH + 1) step();
    mrf[7] = 32'h77;
    setid(1, 5'd0, 5'd0, 5'd7, 1, 1, 0);
    bus.id_a_pc = 1;
    step();
    setid(1, 5'd7, 5'd0, 5'd0, 0, 0, 0);
    #1 cmp("t7_pre_stall", 32'(bus.stall), 32'd1);
    #1 rst = 1'b0;
    #1 check_all_zero("midreset");
    model_reset();
    setid(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    setid(1, 5'd7, 5'd0, 5'd0, 0, 0, 0);
    step();
    cmp("t7_unforwarded", bus.ex_op_a, 32'h77);

    repeat (300) begin
      drive_rand();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
